// File: rtl/uart_tx_feeder.sv
// Byte FIFO feeding a UART transmitter: pops one byte per frame and launches it
// with a one-cycle DV pulse once the transmitter has returned to idle.
module uart_tx_feeder #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 8
) (
  input  logic                  i_Clock,
  input  logic                  i_Rst_n,
  input  logic                  i_Wr_En,
  input  logic [DATA_W-1:0]     i_Wr_Byte,
  input  logic                  i_Clr_Ovf,
  output logic                  o_Full,
  output logic                  o_Empty,
  output logic [DEPTH_LOG2:0]   o_Count,
  output logic                  o_Overflow,
  output logic                  o_Busy,
  output logic                  o_Tx_DV,
  output logic [DATA_W-1:0]     o_Tx_Byte,
  input  logic                  i_Tx_Active,
  input  logic                  i_Tx_Done
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACT,
    WAIT_DONE,
    WAIT_CLR
  } state_t;

  state_t                  state;
  logic [DATA_W-1:0]       mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr;
  logic [DEPTH_LOG2-1:0]   rd_ptr;
  logic                    push;
  logic                    pop;

  assign o_Full  = (o_Count == FULL_CNT);
  assign o_Empty = (o_Count == '0);
  assign o_Busy  = ~o_Empty | (state != IDLE);

  // Both decisions use the pre-edge count, so a full FIFO drops a push even
  // when a pop happens in the same cycle, and a fresh byte cannot pop at once.
  assign push = i_Wr_En & ~o_Full;
  assign pop  = (state == IDLE) & ~o_Empty & ~i_Tx_Active & ~i_Tx_Done;

  always_ff @(posedge i_Clock) begin
    if (push) begin
      mem[wr_ptr] <= i_Wr_Byte;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_Count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   o_Count <= o_Count + 1'b1;
        2'b01:   o_Count <= o_Count - 1'b1;
        default: o_Count <= o_Count;
      endcase
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Overflow <= 1'b0;
    end else if (i_Wr_En && o_Full) begin
      o_Overflow <= 1'b1;
    end else if (i_Clr_Ovf) begin
      o_Overflow <= 1'b0;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state     <= IDLE;
      o_Tx_DV   <= 1'b0;
      o_Tx_Byte <= '0;
    end else begin
      o_Tx_DV <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            o_Tx_DV   <= 1'b1;
            o_Tx_Byte <= mem[rd_ptr];
            state     <= WAIT_ACT;
          end
        end
        WAIT_ACT: begin
          if (i_Tx_Active) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (i_Tx_Done) begin
            state <= WAIT_CLR;
          end
        end
        WAIT_CLR: begin
          // Done stays high two cycles; wait it out so no launch lands mid-handshake.
          if (!i_Tx_Done && !i_Tx_Active) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: behavioural UART transmitter (4 clocks/bit, done high
// 2 cycles), byte scoreboard on DV, serial frame receiver, and a vector table.
module tb_uart_tx_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, wr_en, clr, blk;
  logic [7:0] wr_byte;
  logic       full, empty, ovf, busy, dv;
  logic [4:0] count;
  logic [7:0] tx_byte;

  logic       tx_active = 1'b0;
  logic       tx_done   = 1'b0;
  logic       tx_serial = 1'b1;
  int         tx_ph  = 0;
  int         tx_bit = 0;
  int         tx_cnt = 0;
  logic [9:0] tx_frame = '0;

  int   checks = 0;
  int   errors = 0;
  int   dv_count = 0;
  logic stream_on;
  logic [7:0] exp_q[$];
  logic [7:0] ser_q[$];

  typedef struct {
    logic       wr;
    logic [7:0] b;
    logic       clr;
    logic       blk;
    int         cnt;
    logic       full;
    logic       ovf;
  } vec_t;
  vec_t tbl[21];

  uart_tx_feeder #(.DEPTH_LOG2(4), .DATA_W(8)) dut (
    .i_Clock    (clk),
    .i_Rst_n    (rst_n),
    .i_Wr_En    (wr_en),
    .i_Wr_Byte  (wr_byte),
    .i_Clr_Ovf  (clr),
    .o_Full     (full),
    .o_Empty    (empty),
    .o_Count    (count),
    .o_Overflow (ovf),
    .o_Busy     (busy),
    .o_Tx_DV    (dv),
    .o_Tx_Byte  (tx_byte),
    .i_Tx_Active(tx_active | blk),
    .i_Tx_Done  (tx_done)
  );

  // Transmitter model: samples DV only while idle; not reset with the DUT.
  always @(posedge clk) begin
    case (tx_ph)
      0: if (dv) begin
        tx_frame  <= {1'b1, tx_byte, 1'b0};
        tx_active <= 1'b1;
        tx_serial <= 1'b0;
        tx_bit    <= 0;
        tx_cnt    <= 0;
        tx_ph     <= 1;
      end
      1: if (tx_cnt == 3) begin
        tx_cnt <= 0;
        if (tx_bit == 9) begin
          tx_active <= 1'b0;
          tx_done   <= 1'b1;
          tx_serial <= 1'b1;
          tx_ph     <= 2;
        end else begin
          tx_bit    <= tx_bit + 1;
          tx_serial <= tx_frame[tx_bit+1];
        end
      end else begin
        tx_cnt <= tx_cnt + 1;
      end
      default: if (tx_cnt == 1) begin
        tx_done <= 1'b0;
        tx_cnt  <= 0;
        tx_ph   <= 0;
      end else begin
        tx_cnt <= tx_cnt + 1;
      end
    endcase
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic monitor();
    logic       dv_prev = 1'b0;
    logic       armed = 1'b0;
    int         gap = 0;
    logic [9:0] rx = '0;
    logic [7:0] eb;
    forever begin
      @(negedge clk);
      if (dv) begin
        dv_count++;
        check("dv_one_cycle", dv_prev, 0);
        check("dv_tx_idle", {tx_ph == 0, tx_done, tx_active}, 3'b100);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL dv_unexpected: byte %0h launched, none queued", tx_byte);
        end else begin
          eb = exp_q.pop_front();
          if (tx_byte !== eb) begin
            errors++;
            $display("FAIL dv_byte: got %0h, expected %0h", tx_byte, eb);
          end
          ser_q.push_back(eb);
        end
        if (stream_on && armed) begin
          checks++;
          if (gap < 1 || gap > 2) begin
            errors++;
            $display("FAIL dv_gap: got %0d clocks after done fell, expected 1..2", gap);
          end
        end
        armed = 1'b0;
      end
      if (!stream_on) armed = 1'b0;
      else if (tx_done) begin armed = 1'b1; gap = 0; end
      else if (armed && !dv) gap++;
      if (tx_ph == 1 && tx_cnt == 2) begin
        rx[tx_bit] = tx_serial;
        if (tx_bit == 9) begin
          checks++;
          if (ser_q.size() == 0) begin
            errors++;
            $display("FAIL serial_unexpected: frame %0h, none expected", rx);
          end else begin
            eb = ser_q.pop_front();
            if (rx !== {1'b1, eb, 1'b0}) begin
              errors++;
              $display("FAIL serial_frame: got %0h, expected %0h", rx, {1'b1, eb, 1'b0});
            end
          end
        end
      end
      dv_prev = dv;
    end
  endtask

  task automatic drive(input logic w, input logic [7:0] b, input logic c, input logic acc);
    wr_en = w; wr_byte = b; clr = c;
    if (acc) exp_q.push_back(b);
    @(negedge clk);
    wr_en = 1'b0; clr = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while (!(empty && !busy && tx_ph == 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_drain_in_time"}, n < 3000, 1);
    check({nm, "_sb_empty"}, exp_q.size() + ser_q.size(), 0);
  endtask

  initial begin
    int prev;
    int d0;
    int n;
    rst_n = 1'b0; wr_en = 1'b0; wr_byte = '0; clr = 1'b0; blk = 1'b0; stream_on = 1'b0;

    for (int i = 0; i < 17; i++) begin
      tbl[i] = '{wr: 1'b1, b: 8'(8'h10 + i), clr: 1'b0, blk: (i != 5),
                 cnt: (i < 5) ? i + 1 : (i == 5) ? 5 : i, full: (i == 16), ovf: 1'b0};
    end
    tbl[17] = '{1'b1, 8'hEE, 1'b1, 1'b1, 16, 1'b1, 1'b1};
    tbl[18] = '{1'b0, 8'h00, 1'b1, 1'b1, 16, 1'b1, 1'b0};
    tbl[19] = '{1'b1, 8'hEF, 1'b0, 1'b1, 16, 1'b1, 1'b1};
    tbl[20] = '{1'b0, 8'h00, 1'b1, 1'b1, 16, 1'b1, 1'b0};

    fork monitor(); join_none

    repeat (3) @(negedge clk);
    check("rst_count", count, 0);
    check("rst_flags", {empty, full, ovf, busy, dv}, 5'b10000);
    check("rst_tx_byte", tx_byte, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single byte: DV on the edge after the push edge.
    drive(1'b1, 8'hA5, 1'b0, 1'b1);
    check("lat_dv_at_push_edge", dv, 0);
    check("lat_count", count, 1);
    @(negedge clk);
    check("lat_dv_next_edge", dv, 1);
    check("lat_byte", tx_byte, 8'hA5);
    @(negedge clk);
    check("lat_dv_falls", dv, 0);
    check("lat_byte_held", tx_byte, 8'hA5);
    wait_drain("single");

    // Burst of 16 while transmitter appears busy, then a dropped 17th.
    blk = 1'b1;
    for (int i = 0; i < 16; i++) drive(1'b1, 8'(i), 1'b0, 1'b1);
    check("burst_full", full, 1);
    check("burst_count", count, 16);
    drive(1'b1, 8'hFF, 1'b0, 1'b0);
    check("burst_ovf", ovf, 1);
    check("burst_count_after_drop", count, 16);
    d0 = dv_count;
    blk = 1'b0;
    wait_drain("burst");
    check("burst_dv_pulses", dv_count - d0, 16);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check("burst_ovf_clr", ovf, 0);

    // Vector table: push/pop at count 5, fill, overflow set-vs-clear priority.
    prev = 0;
    for (int i = 0; i < 21; i++) begin
      blk = tbl[i].blk;
      drive(tbl[i].wr, tbl[i].b, tbl[i].clr, tbl[i].wr && prev < 16);
      check($sformatf("vec%0d_count", i), count, tbl[i].cnt);
      check($sformatf("vec%0d_flags", i), {full, empty, ovf}, {tbl[i].full, tbl[i].cnt == 0, tbl[i].ovf});
      prev = tbl[i].cnt;
    end

    // Full FIFO, push and pop in the same cycle: pop wins the slot, push dropped.
    n = 0;
    while (!(tx_ph == 0) && n < 200) begin @(negedge clk); n++; end
    check("fullpop_tx_idle_in_time", n < 200, 1);
    blk = 1'b0;
    @(negedge clk);
    check("fullpop_count_before", count, 16);
    drive(1'b1, 8'hAB, 1'b0, 1'b0);
    check("fullpop_count", count, 15);
    check("fullpop_ovf", ovf, 1);
    check("fullpop_dv", dv, 1);
    wait_drain("table");
    drive(1'b0, 8'h00, 1'b1, 1'b0);

    // Paced stream of 20 bytes: frames back-to-back with 1-2 clock gaps.
    stream_on = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 8'(8'h40 + i), 1'b0, 1'b1);
      if (i >= 1) repeat (29) @(negedge clk);
    end
    n = 0;
    while (busy && n < 3000) begin @(negedge clk); n++; end
    check("stream_busy_falls", n < 3000, 1);
    check("stream_busy_after_done", {tx_active, tx_done, empty, tx_ph == 0}, 4'b0011);
    stream_on = 1'b0;
    wait_drain("stream");

    // Reset mid-frame with 3 bytes queued; no launch until transmitter is idle.
    for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'h60 + i), 1'b0, 1'b1);
    n = 0;
    while (!(tx_ph == 1 && tx_bit == 4) && n < 200) begin @(negedge clk); n++; end
    check("midrst_reached_frame", n < 200, 1);
    check("midrst_queued", count, 3);
    rst_n = 1'b0;
    #1;
    check("midrst_count", count, 0);
    check("midrst_flags", {empty, full, ovf, busy, dv}, 5'b10000);
    check("midrst_tx_byte", tx_byte, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 8'h3C, 1'b0, 1'b1);
    check("midrst_held_off", {dv, count}, {1'b0, 5'd1});
    wait_drain("midrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
